trace_buffer_dp: RTL and testbench

Double-buffered, parametrised column trace store between the raycaster (writer) and the VGA renderer (reader). The tracer fills a back bank with one height and side entry per screen column while the renderer reads the front bank. Banks swap only at vertical sync, and only after the tracer has declared its frame complete, so a displayed frame never contains a mix of two traces. An optional hardware clear engine zeroes the new back bank after each swap.

---
 rtl/trace_buffer_dp.sv | 234 +++++++++++++++++++++++
 tb/tb_trace_buffer_dp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer_dp.sv
// -----------------------------------------------------------------------------
// trace_buffer_dp
//
// Double-buffered column trace store between the raycaster (writer) and the
// VGA renderer (reader). The tracer fills the back bank (index !front_bank)
// with one {side, height} entry per screen column. The renderer reads the
// front bank. Banks swap only on vsync, and only after the tracer has
// signalled wr_done, so a displayed frame never mixes two traces.
//
// Optional feature macro: TRACE_BUFFER_CLEAR_EN
//   When it is defined, a clear engine zeroes the new back bank after every
//   swap and after reset, one column per cycle, before FILL is entered.
//   When it is undefined, the back bank keeps stale data and reset enters
//   FILL directly.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   wr_en/wr_column/      : back-bank write request (accepted in FILL only)
//   wr_height/wr_side
//   wr_done               : tracer finished the back frame (FILL -> WAIT_SWAP)
//   wr_ready              : high while in FILL
//   vsync                 : start of vertical blank, swaps banks in WAIT_SWAP
//   rd_en/rd_column       : front-bank read request
//   rd_height/rd_side     : registered read data (1-cycle latency)
//   rd_valid              : read data valid this cycle
//   front_bank            : bank index currently displayed
//   swapped               : one-cycle pulse after each swap
//   overflow              : sticky, a write arrived outside FILL
// -----------------------------------------------------------------------------
module trace_buffer_dp #(
  parameter int COLUMNS  = 640,
  parameter int COL_W    = 10,
  parameter int HEIGHT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [COL_W-1:0]    wr_column,
  input  logic [HEIGHT_W-1:0] wr_height,
  input  logic                wr_side,
  input  logic                wr_done,
  output logic                wr_ready,
  input  logic                vsync,
  input  logic                rd_en,
  input  logic [COL_W-1:0]    rd_column,
  output logic [HEIGHT_W-1:0] rd_height,
  output logic                rd_side,
  output logic                rd_valid,
  output logic                front_bank,
  output logic                swapped,
  output logic                overflow
);

  localparam int COL_WP1 = COL_W + 1;
  // One extra bit so the range check also works when COLUMNS == 2**COL_W.
  localparam logic [COL_W:0] COLS_EXT = COL_WP1'(COLUMNS);

`ifdef TRACE_BUFFER_CLEAR_EN
  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_WAIT_SWAP = 2'd1,
    ST_CLEAR     = 2'd2
  } state_e;
  localparam state_e RESET_STATE = ST_CLEAR;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
`else
  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_WAIT_SWAP = 2'd1
  } state_e;
  localparam state_e RESET_STATE = ST_FILL;
`endif

  state_e state_q, state_d;
  logic   front_q, front_d;
  logic   swapped_q, swap_s;
  logic   overflow_q, overflow_d;
  logic   rd_valid_q;
  logic   [HEIGHT_W-1:0] rd_height_q;
  logic   rd_side_q;

`ifdef TRACE_BUFFER_CLEAR_EN
  logic [COL_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Storage: two banks of {side, height}; contents are deliberately not reset.
  logic [HEIGHT_W:0] mem_q [0:1][0:COLUMNS-1];

  logic                mem_we_s;
  logic                mem_bank_s;
  logic [COL_W-1:0]    mem_addr_s;
  logic [HEIGHT_W:0]   mem_wdata_s;
  logic                wr_in_range_s;
  logic                rd_in_range_s;

  assign wr_in_range_s = ({1'b0, wr_column} < COLS_EXT);
  assign rd_in_range_s = ({1'b0, rd_column} < COLS_EXT);
  assign mem_bank_s    = ~front_q;

  // Next-state, swap and back-bank write port selection.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_s      = 1'b0;
    overflow_d  = overflow_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = wr_column;
    mem_wdata_s = {wr_side, wr_height};
`ifdef TRACE_BUFFER_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    // Any write outside FILL is dropped and remembered, in range or not.
    if (wr_en && (state_q != ST_FILL)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_FILL: begin
        // Out-of-range columns are silently ignored.
        if (wr_en && wr_in_range_s) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
        // vsync in FILL is ignored even if wr_done arrives with it.
        if (wr_done) begin
          state_d = ST_WAIT_SWAP;
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_WAIT_SWAP: begin
        if (vsync) begin
          front_d = ~front_q;
          swap_s  = 1'b1;
`ifdef TRACE_BUFFER_CLEAR_EN
          state_d   = ST_CLEAR;
          clr_cnt_d = {COL_W{1'b0}};
`else
          state_d = ST_FILL;
`endif
        end else begin
          state_d = ST_WAIT_SWAP;
        end
      end

`ifdef TRACE_BUFFER_CLEAR_EN
      ST_CLEAR: begin
        // Sweep zeros across the back bank, one column per cycle.
        mem_we_s    = 1'b1;
        mem_addr_s  = clr_cnt_q;
        mem_wdata_s = {(HEIGHT_W + 1){1'b0}};
        if (clr_cnt_q == LAST_COL) begin
          state_d   = ST_FILL;
          clr_cnt_d = {COL_W{1'b0}};
        end else begin
          state_d   = ST_CLEAR;
          clr_cnt_d = clr_cnt_q + {{(COL_W - 1){1'b0}}, 1'b1};
        end
      end
`endif

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Control state, bank select and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      front_q    <= 1'b0;
      swapped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      swapped_q  <= swap_s;
      overflow_q <= overflow_d;
    end
  end

`ifdef TRACE_BUFFER_CLEAR_EN
  // Clear sweep column counter; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q <= {COL_W{1'b0}};
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  // Back-bank write port (no reset on storage).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_bank_s][mem_addr_s] <= mem_wdata_s;
    end
  end

  // Front-bank read port. front_q is sampled before the swap takes effect,
  // so a read in the swap cycle still sees the old front bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q  <= 1'b0;
      rd_height_q <= {HEIGHT_W{1'b0}};
      rd_side_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (rd_in_range_s) begin
          {rd_side_q, rd_height_q} <= mem_q[front_q][rd_column];
        end else begin
          rd_side_q   <= 1'b0;
          rd_height_q <= {HEIGHT_W{1'b0}};
        end
      end
    end
  end

  assign wr_ready   = (state_q == ST_FILL);
  assign rd_height  = rd_height_q;
  assign rd_side    = rd_side_q;
  assign rd_valid   = rd_valid_q;
  assign front_bank = front_q;
  assign swapped    = swapped_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_buffer_dp.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer_dp
//
// Scoreboard bench for trace_buffer_dp. Each issued read pushes its expected
// {side, height} and issue cycle into a queue; a monitor pops and compares
// whenever rd_valid is high. Control/status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_trace_buffer_dp;

  localparam int COLUMNS  = 640;
  localparam int COL_W    = 10;
  localparam int HEIGHT_W = 8;

`ifdef TRACE_BUFFER_CLEAR_EN
  localparam logic RDY_AFTER_SWAP = 1'b0;
`else
  localparam logic RDY_AFTER_SWAP = 1'b1;
`endif

  logic                clk;
  logic                reset_n;
  logic                wr_en;
  logic [COL_W-1:0]    wr_column;
  logic [HEIGHT_W-1:0] wr_height;
  logic                wr_side;
  logic                wr_done;
  logic                wr_ready;
  logic                vsync;
  logic                rd_en;
  logic [COL_W-1:0]    rd_column;
  logic [HEIGHT_W-1:0] rd_height;
  logic                rd_side;
  logic                rd_valid;
  logic                front_bank;
  logic                swapped;
  logic                overflow;

  typedef struct {
    logic [8:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;

  trace_buffer_dp #(
    .COLUMNS (COLUMNS),
    .COL_W   (COL_W),
    .HEIGHT_W(HEIGHT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_column (wr_column),
    .wr_height (wr_height),
    .wr_side   (wr_side),
    .wr_done   (wr_done),
    .wr_ready  (wr_ready),
    .vsync     (vsync),
    .rd_en     (rd_en),
    .rd_column (rd_column),
    .rd_height (rd_height),
    .rd_side   (rd_side),
    .rd_valid  (rd_valid),
    .front_bank(front_bank),
    .swapped   (swapped),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid must match the oldest pending read, one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid=1 with no read pending (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", {23'd0, rd_side, rd_height}, {23'd0, e.data});
        chk("rd_latency", cyc_cnt, e.cyc + 1);
      end
    end
  end

  task automatic rd_issue(input int col, input logic [8:0] exp_data);
    exp_t e;
    rd_en     = 1'b1;
    rd_column = 10'(col);
    e.data    = exp_data;
    e.cyc     = cyc_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!wr_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_column = 10'd0;
    wr_height = 8'd0;
    wr_side   = 1'b0;
    wr_done   = 1'b0;
    vsync     = 1'b0;
    rd_en     = 1'b0;
    rd_column = 10'd0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_rd_height", {24'd0, rd_height}, 32'd0);
    chk("rst_rd_side", {31'd0, rd_side}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_front", {31'd0, front_bank}, 32'd0);
    chk("rst_swapped", {31'd0, swapped}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, {31'd0, RDY_AFTER_SWAP});
    reset_n = 1'b1;
    @(negedge clk);
    wait_ready();

    // Fill bank 1: height = col[7:0], side = col[0]; last write carries wr_done.
    for (int c = 0; c < COLUMNS; c++) begin
      wr_en     = 1'b1;
      wr_column = 10'(c);
      wr_height = 8'(c);
      wr_side   = c[0];
      wr_done   = (c == COLUMNS - 1);
      @(negedge clk);
    end
    wr_en   = 1'b0;
    wr_done = 1'b0;
    chk("wr_ready_wait_swap", {31'd0, wr_ready}, 32'd0);
    chk("front_before_swap", {31'd0, front_bank}, 32'd0);

    // First swap.
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    chk("front_swap1", {31'd0, front_bank}, 32'd1);
    chk("swapped_swap1", {31'd0, swapped}, 32'd1);
    @(negedge clk);
    chk("swapped_pulse1", {31'd0, swapped}, 32'd0);
    wait_ready();

    // Reads from new front (bank 1); col 700 read and write together.
    rd_issue(5, {1'b1, 8'd5});
    rd_issue(639, {1'b1, 8'd127});
    wr_en     = 1'b1;
    wr_column = 10'd700;
    wr_height = 8'h77;
    wr_side   = 1'b1;
    rd_issue(700, 9'd0);
    wr_en = 1'b0;
    chk("overflow_oor", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    chk("rd_valid_one_cycle", {31'd0, rd_valid}, 32'd0);

    // vsync in FILL without wr_done: no swap.
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    chk("front_no_swap", {31'd0, front_bank}, 32'd1);
    chk("swapped_no_swap", {31'd0, swapped}, 32'd0);
    chk("wr_ready_no_swap", {31'd0, wr_ready}, 32'd1);

    // Fill bank 0: A5/0 everywhere except col 3 = 33/1; wr_done+vsync together.
    for (int c = 0; c < COLUMNS; c++) begin
      wr_en     = 1'b1;
      wr_column = 10'(c);
      wr_height = (c == 3) ? 8'h33 : 8'hA5;
      wr_side   = (c == 3);
      wr_done   = (c == COLUMNS - 1);
      vsync     = (c == COLUMNS - 1);
      @(negedge clk);
    end
    wr_en   = 1'b0;
    wr_done = 1'b0;
    vsync   = 1'b0;
    chk("wr_ready_done_vsync", {31'd0, wr_ready}, 32'd0);
    chk("front_done_vsync", {31'd0, front_bank}, 32'd1);
    chk("swapped_done_vsync", {31'd0, swapped}, 32'd0);

    // Write dropped in WAIT_SWAP sets sticky overflow.
    wr_en     = 1'b1;
    wr_column = 10'd3;
    wr_height = 8'hEE;
    wr_side   = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    chk("swapped_still0", {31'd0, swapped}, 32'd0);
    @(negedge clk);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Swap with a read in the swap cycle: old front (bank 1) data.
    vsync = 1'b1;
    rd_issue(5, {1'b1, 8'd5});
    vsync = 1'b0;
    chk("front_swap2", {31'd0, front_bank}, 32'd0);
    chk("swapped_swap2", {31'd0, swapped}, 32'd1);
    chk("wr_ready_after_swap2", {31'd0, wr_ready}, {31'd0, RDY_AFTER_SWAP});
    @(negedge clk);
    chk("swapped_pulse2", {31'd0, swapped}, 32'd0);
`ifdef TRACE_BUFFER_CLEAR_EN
    n = 2;
    while (!wr_ready && n < 2000) begin
      @(negedge clk);
      if (!wr_ready) n++;
    end
    chk("clear_cycles", n, 32'd640);
`endif

    // Reads from bank 0; col 3 keeps its pre-drop value.
    rd_issue(3, {1'b1, 8'h33});
    rd_issue(5, {1'b0, 8'hA5});
    rd_issue(0, {1'b0, 8'hA5});
    rd_issue(2, {1'b0, 8'hA5});
    @(negedge clk);
    chk("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
    chk("rd_height_hold", {24'd0, rd_height}, 32'h0000_00A5);
    chk("overflow_final", {31'd0, overflow}, 32'd1);

`ifdef TRACE_BUFFER_CLEAR_EN
    // Bank 1 was cleared after the last swap: write only col 10 and swap.
    wr_en     = 1'b1;
    wr_column = 10'd10;
    wr_height = 8'h5A;
    wr_side   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    vsync   = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    chk("front_swap3", {31'd0, front_bank}, 32'd1);
    rd_issue(10, {1'b1, 8'h5A});
    rd_issue(11, 9'd0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
